spi_slave_gen: RTL

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_slave_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_gen.sv
// SPI slave front end: shifts in {cmd[1:0], payload} frames on MOSI, hands
// accepted frames to the core on rx_data/rx_valid, and for read-data frames
// waits for tx_data and shifts it back out on MISO.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | SS_n high, nothing in flight
// S_CHK_CMD   | first selected cycle, MOSI bit picks write or read path
// S_WRITE     | write frame (cmd 00/01)
// S_READ_ADD  | read-address frame (cmd 10), arms rd_add_flag
// S_READ_DATA | read-data frame (cmd 11), then wait for tx_valid and send
//
// The three frame states share a sub-phase: receive bits, check command,
// wait for tx_valid, transmit, then hold quietly until SS_n rises.
module spi_slave_gen #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              cmd_err,
  output logic              busy
);

  localparam int RXC_W = ($clog2(DATA_W + 2) > 0) ? $clog2(DATA_W + 2) : 1;
  localparam int TXC_W = ($clog2(DATA_W + 1) > 0) ? $clog2(DATA_W + 1) : 1;
  localparam int WTC_W = ($clog2(TX_WAIT_MAX + 1) > 0) ? $clog2(TX_WAIT_MAX + 1) : 1;

  localparam logic [RXC_W-1:0] RX_LAST  = RXC_W'(DATA_W + 1);
  localparam logic [RXC_W-1:0] RX_ONE   = RXC_W'(1);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_W - 1);
  localparam logic [TXC_W-1:0] TX_ONE   = TXC_W'(1);
  localparam logic [WTC_W-1:0] WAIT_MAX = WTC_W'(TX_WAIT_MAX);
  localparam logic [WTC_W-1:0] WAIT_ONE = WTC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_CMD,
    S_WRITE,
    S_READ_ADD,
    S_READ_DATA
  } state_e;

  typedef enum logic [2:0] {
    P_RX,
    P_CHK,
    P_WAIT,
    P_TX,
    P_HOLD
  } phase_e;

  state_e              state_q;
  phase_e              phase_q;
  logic                rd_add_flag_q;
  logic [RXC_W-1:0]    rx_cnt_q;
  logic [TXC_W-1:0]    tx_cnt_q;
  logic [WTC_W-1:0]    wait_cnt_q;
  logic [DATA_W+1:0]   rx_data_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic                miso_q;
  logic                rx_valid_q;
  logic                cmd_err_q;
  logic                frame_err_q;
  logic [1:0]          cmd_code;
  logic                cmd_ok;

  assign cmd_code = rx_data_q[DATA_W+1:DATA_W];

  // Command code acceptance for the path chosen by the select bit.
  always_comb begin
    cmd_ok = 1'b0;
    case (state_q)
      S_WRITE:     cmd_ok = ~cmd_code[1];
      S_READ_ADD:  cmd_ok = (cmd_code == 2'b10);
      S_READ_DATA: cmd_ok = (cmd_code == 2'b11);
      default:     cmd_ok = 1'b0;
    endcase
  end

  // Main FSM with registered strobes, MISO and the read-address flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= P_HOLD;
      rd_add_flag_q <= 1'b0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      rx_data_q     <= '0;
      tx_sh_q       <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q != S_IDLE && SS_n) begin
        // Deselect wins; anything short of a finished frame is an abort.
        state_q <= S_IDLE;
        miso_q  <= 1'b0;
        if (state_q == S_CHK_CMD || phase_q != P_HOLD) frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!SS_n) state_q <= S_CHK_CMD;
          end
          S_CHK_CMD: begin
            phase_q  <= P_RX;
            rx_cnt_q <= RX_LAST;
            if (!MOSI)              state_q <= S_WRITE;
            else if (rd_add_flag_q) state_q <= S_READ_DATA;
            else                    state_q <= S_READ_ADD;
          end
          default: begin
            case (phase_q)
              P_RX: begin
                rx_data_q <= {rx_data_q[DATA_W:0], MOSI};
                if (rx_cnt_q == '0) phase_q <= P_CHK;
                else                rx_cnt_q <= rx_cnt_q - RX_ONE;
              end
              P_CHK: begin
                if (cmd_ok) begin
                  rx_valid_q <= 1'b1;
                  if (state_q == S_READ_ADD) rd_add_flag_q <= 1'b1;
                  if (state_q == S_READ_DATA) begin
                    phase_q    <= P_WAIT;
                    wait_cnt_q <= WAIT_MAX;
                  end else begin
                    phase_q <= P_HOLD;
                  end
                end else begin
                  cmd_err_q <= 1'b1;
                  phase_q   <= P_HOLD;
                end
              end
              P_WAIT: begin
                if (tx_valid) begin
                  miso_q   <= tx_data[DATA_W-1];
                  tx_sh_q  <= tx_data << 1;
                  tx_cnt_q <= TX_LAST;
                  phase_q  <= P_TX;
                end else if (wait_cnt_q == '0) begin
                  frame_err_q <= 1'b1;
                  phase_q     <= P_HOLD;
                end else begin
                  wait_cnt_q <= wait_cnt_q - WAIT_ONE;
                end
              end
              P_TX: begin
                if (tx_cnt_q == '0) begin
                  miso_q        <= 1'b0;
                  rd_add_flag_q <= 1'b0;
                  phase_q       <= P_HOLD;
                end else begin
                  miso_q   <= tx_sh_q[DATA_W-1];
                  tx_sh_q  <= tx_sh_q << 1;
                  tx_cnt_q <= tx_cnt_q - TX_ONE;
                end
              end
              default: begin
                miso_q <= 1'b0;
              end
            endcase
          end
        endcase
      end
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
